key_sequencer: RTL and testbench
================================

Name: key_sequencer

Overview:
- Sits directly downstream of the keypad button reader. Consumes its 5-bit key codes over a valid/ready handshake.
- Assembles hex operands digit by digit and tracks the selected operator.
- Issues {A, B, op} requests to the arithmetic unit, then takes the result back as the new A for chained operations.
- Drives the value to display and an error flag.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_key_data  input  5  key code from button reader
- i_key_valid  input  1  key code valid
- o_key_ready  output  1  sequencer can accept a key this cycle
- o_op_a  output  WIDTH  operand A of issued request
- o_op_b  output  WIDTH  operand B of issued request
- o_op_code  output  2  0=add, 1=sub, 2=mul, 3=div
- o_op_valid  output  1  request valid
- i_op_ready  input  1  arithmetic unit accepts request
- i_result  input  WIDTH  result value
- i_result_valid  input  1  single-cycle result strobe
- i_result_error  input  1  qualifies i_result_valid; divide-by-zero or overflow
- o_display  output  WIDTH  value to display
- o_error  output  1  error state indicator

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous, active-high.
- Reset values: state=S_A; A=0; B=0; op=0; next_op=0; a_is_result=0; o_op_valid=0; o_error=0; o_display=0.
- Key codes:
  - bit4=0: digit, value = bits[3:0] (0..15).
  - bits[4:3]=10: function, bits[2:0]: 0=AC, 1=+, 2=-, 3=*, 4=/, 5==.
  - Codes 10110, 10111 and 11xxx are accepted and ignored.
- Key accept: a key is accepted when i_key_valid && o_key_ready. Its effect is visible after the next rising edge.
- o_key_ready: 1 in S_A, S_OP, S_B, S_ERR; 0 in S_ISSUE, S_WAIT.
- Digit append: acc <= {acc[WIDTH-5:0], d}, applied only if acc[WIDTH-1:WIDTH-4]==0. Otherwise the digit is accepted and dropped (no wrap).
- S_A (entering A):
  - digit: if a_is_result, A<=d and clear a_is_result; else append to A.
  - + - * /: op<=code-1, clear a_is_result, go to S_OP.
  - =: ignored.
- S_OP (operator selected, B empty):
  - digit: B<=d, go to S_B.
  - + - * /: replace op.
  - =: ignored.
- S_B (entering B):
  - digit: append to B.
  - + - * /: next_op<=code-1, chain<=1, go to S_ISSUE.
  - =: chain<=0, go to S_ISSUE.
- S_ISSUE:
  - o_op_valid=1; o_op_a=A, o_op_b=B, o_op_code=op, all held stable while valid.
  - o_op_valid asserts the cycle after the key that caused entry.
  - i_op_ready high: o_op_valid falls next cycle, go to S_WAIT.
- S_WAIT, on i_result_valid:
  - If i_result_error: go to S_ERR.
  - Else A<=i_result, B<=0.
    - chain=1: op<=next_op, go to S_OP.
    - chain=0: set a_is_result, go to S_A.
  - A result arriving in the same cycle as the i_op_ready handshake is ignored; the result is only taken in S_WAIT.
  - i_result_valid in any other state is ignored.
- S_ERR: o_error=1, o_display=0; all keys except AC are ignored.
- AC (any accepting state): A=B=op=next_op=0, clear a_is_result, o_error=0, go to S_A.
- o_display:
  - S_A and S_OP: A.
  - S_B, S_ISSUE, S_WAIT: B.
  - S_ERR: 0.
  - Registered; updates with state.
- Reset mid-request: rst during S_ISSUE or S_WAIT drops o_op_valid next cycle and returns to reset values. Any later i_result_valid is ignored.

Test Plan:
- Reset, keys 0x01, 0x02, +(10001), 0x03, =(10101); return result 0x15 on the cycle after handshake.
  - Request A=0x0012, B=0x0003, op=0.
  - Then o_display=0x0015, state S_A.
- Chain: 5, *(10011), 4, -(10010); result 0x14; then 2, =.
  - Second request A=0x0014, B=0x0002, op=1.
- Overflow at WIDTH=16: five digits 1,2,3,4,5 -> A=0x1234; fifth digit consumed, display unchanged.
- Hold i_op_ready=0 for 5 cycles with valid high:
  - o_key_ready=0; operands stable; keys are not consumed.
  - On ready: o_op_valid drops next cycle.
- Division path, error: 8, /(10100), 0, =; result with i_result_error=1.
  - o_error=1, display 0; digit 7 ignored.
  - AC(10000) -> o_error=0, A=0, S_A.
- After =, result 0x9; type digit 3 -> A=0x0003, not 0x0093. Operator twice (+ then -) in S_OP -> op=1. rst asserted in S_WAIT -> outputs return to reset values.

Source files
------------

// File: rtl/key_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : key_sequencer
//  Description : Turns keypad key codes into {A, B, op} arithmetic requests,
//                chains results back into A and drives display/error.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_key_data,
    input  logic             i_key_valid,
    output logic             o_key_ready,
    output logic [WIDTH-1:0] o_op_a,
    output logic [WIDTH-1:0] o_op_b,
    output logic [1:0]       o_op_code,
    output logic             o_op_valid,
    input  logic             i_op_ready,
    input  logic [WIDTH-1:0] i_result,
    input  logic             i_result_valid,
    input  logic             i_result_error,
    output logic [WIDTH-1:0] o_display,
    output logic             o_error
);

    localparam logic [2:0] S_A     = 3'd0;
    localparam logic [2:0] S_OP    = 3'd1;
    localparam logic [2:0] S_B     = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]       r_state, w_state_nx;
    logic [WIDTH-1:0] r_a, w_a_nx;
    logic [WIDTH-1:0] r_b, w_b_nx;
    logic [1:0]       r_op, w_op_nx;
    logic [1:0]       r_next_op, w_next_op_nx;
    logic             r_chain, w_chain_nx;
    logic             r_a_is_result, w_a_is_result_nx;
    logic [WIDTH-1:0] r_display, w_display_nx;
    logic             r_error;
    logic             r_op_valid;

    logic             w_fire;
    logic             w_is_digit;
    logic             w_is_ac;
    logic             w_is_arith;
    logic             w_is_eq;
    logic [WIDTH-1:0] w_digit;
    logic [1:0]       w_fop;

    assign o_key_ready = (r_state != S_ISSUE) && (r_state != S_WAIT);
    assign w_fire      = i_key_valid && o_key_ready;
    assign w_is_digit  = ~i_key_data[4];
    assign w_is_ac     = (i_key_data[4:3] == 2'b10) && (i_key_data[2:0] == 3'd0);
    assign w_is_arith  = (i_key_data[4:3] == 2'b10) && (i_key_data[2:0] >= 3'd1)
                         && (i_key_data[2:0] <= 3'd4);
    assign w_is_eq     = (i_key_data[4:3] == 2'b10) && (i_key_data[2:0] == 3'd5);
    assign w_digit     = {{(WIDTH-4){1'b0}}, i_key_data[3:0]};
    // Function codes 1..4 map onto op codes 0..3; code 4 wraps to 3 in 2 bits.
    assign w_fop       = i_key_data[1:0] - 2'd1;

    // Shift a digit in only while the top nibble is empty; otherwise drop it.
    function automatic logic [WIDTH-1:0] f_append(input logic [WIDTH-1:0] acc,
                                                  input logic [3:0] d);
        if (acc[WIDTH-1:WIDTH-4] == 4'd0)
            f_append = {acc[WIDTH-5:0], d};
        else
            f_append = acc;
    endfunction

    always_comb begin
        w_state_nx       = r_state;
        w_a_nx           = r_a;
        w_b_nx           = r_b;
        w_op_nx          = r_op;
        w_next_op_nx     = r_next_op;
        w_chain_nx       = r_chain;
        w_a_is_result_nx = r_a_is_result;
        w_display_nx     = '0;

        case (r_state)
            S_A: begin
                if (w_fire && w_is_digit) begin
                    if (r_a_is_result) begin
                        w_a_nx           = w_digit;
                        w_a_is_result_nx = 1'b0;
                    end else begin
                        w_a_nx = f_append(r_a, i_key_data[3:0]);
                    end
                end else if (w_fire && w_is_arith) begin
                    w_op_nx          = w_fop;
                    w_a_is_result_nx = 1'b0;
                    w_state_nx       = S_OP;
                end
            end
            S_OP: begin
                if (w_fire && w_is_digit) begin
                    w_b_nx     = w_digit;
                    w_state_nx = S_B;
                end else if (w_fire && w_is_arith) begin
                    w_op_nx = w_fop;
                end
            end
            S_B: begin
                if (w_fire && w_is_digit) begin
                    w_b_nx = f_append(r_b, i_key_data[3:0]);
                end else if (w_fire && w_is_arith) begin
                    w_next_op_nx = w_fop;
                    w_chain_nx   = 1'b1;
                    w_state_nx   = S_ISSUE;
                end else if (w_fire && w_is_eq) begin
                    w_chain_nx = 1'b0;
                    w_state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_op_ready)
                    w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (i_result_valid) begin
                    if (i_result_error) begin
                        w_state_nx = S_ERR;
                    end else begin
                        w_a_nx = i_result;
                        w_b_nx = '0;
                        if (r_chain) begin
                            w_op_nx    = r_next_op;
                            w_state_nx = S_OP;
                        end else begin
                            w_a_is_result_nx = 1'b1;
                            w_state_nx       = S_A;
                        end
                    end
                end
            end
            S_ERR: ;
            default: w_state_nx = S_A;
        endcase

        // AC wins in every state that accepts keys, including S_ERR.
        if (w_fire && w_is_ac) begin
            w_a_nx           = '0;
            w_b_nx           = '0;
            w_op_nx          = 2'd0;
            w_next_op_nx     = 2'd0;
            w_a_is_result_nx = 1'b0;
            w_state_nx       = S_A;
        end

        case (w_state_nx)
            S_A, S_OP:              w_display_nx = w_a_nx;
            S_B, S_ISSUE, S_WAIT:   w_display_nx = w_b_nx;
            default:                w_display_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_A;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= 2'd0;
            r_next_op     <= 2'd0;
            r_chain       <= 1'b0;
            r_a_is_result <= 1'b0;
            r_display     <= '0;
            r_error       <= 1'b0;
            r_op_valid    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_a           <= w_a_nx;
            r_b           <= w_b_nx;
            r_op          <= w_op_nx;
            r_next_op     <= w_next_op_nx;
            r_chain       <= w_chain_nx;
            r_a_is_result <= w_a_is_result_nx;
            r_display     <= w_display_nx;
            r_error       <= (w_state_nx == S_ERR);
            r_op_valid    <= (w_state_nx == S_ISSUE);
        end
    end

    assign o_op_a     = r_a;
    assign o_op_b     = r_b;
    assign o_op_code  = r_op;
    assign o_op_valid = r_op_valid;
    assign o_display  = r_display;
    assign o_error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_key_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_key_sequencer
//  Description : Directed self-checking bench for key_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_sequencer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       i_key_data;
    logic             i_key_valid;
    logic             o_key_ready;
    logic [WIDTH-1:0] o_op_a;
    logic [WIDTH-1:0] o_op_b;
    logic [1:0]       o_op_code;
    logic             o_op_valid;
    logic             i_op_ready;
    logic [WIDTH-1:0] i_result;
    logic             i_result_valid;
    logic             i_result_error;
    logic [WIDTH-1:0] o_display;
    logic             o_error;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    key_sequencer #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_key_data     (i_key_data),
        .i_key_valid    (i_key_valid),
        .o_key_ready    (o_key_ready),
        .o_op_a         (o_op_a),
        .o_op_b         (o_op_b),
        .o_op_code      (o_op_code),
        .o_op_valid     (o_op_valid),
        .i_op_ready     (i_op_ready),
        .i_result       (i_result),
        .i_result_valid (i_result_valid),
        .i_result_error (i_result_error),
        .o_display      (o_display),
        .o_error        (o_error)
    );

    localparam logic [4:0] K_AC  = 5'b10000;
    localparam logic [4:0] K_ADD = 5'b10001;
    localparam logic [4:0] K_SUB = 5'b10010;
    localparam logic [4:0] K_MUL = 5'b10011;
    localparam logic [4:0] K_DIV = 5'b10100;
    localparam logic [4:0] K_EQ  = 5'b10101;

    typedef struct {
        logic [4:0]       key;
        logic [WIDTH-1:0] disp;
        logic             err;
        logic             kr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clk);
        i_key_data  = k;
        i_key_valid = 1'b1;
        @(negedge clk);
        i_key_valid = 1'b0;
    endtask

    task automatic pulse_result(input logic [WIDTH-1:0] res, input logic err);
        i_result       = res;
        i_result_error = err;
        i_result_valid = 1'b1;
        @(negedge clk);
        i_result_valid = 1'b0;
        i_result_error = 1'b0;
    endtask

    // Called right after the key that enters S_ISSUE; junk result during handshake must be ignored.
    task automatic issue(input string tag, input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                         input logic [1:0] eop, input logic [WIDTH-1:0] res, input logic err);
        check({tag, " op_valid"}, 32'(o_op_valid), 32'd1);
        check({tag, " op_a"}, 32'(o_op_a), 32'(ea));
        check({tag, " op_b"}, 32'(o_op_b), 32'(eb));
        check({tag, " op_code"}, 32'(o_op_code), 32'(eop));
        check({tag, " key_ready"}, 32'(o_key_ready), 32'd0);
        i_op_ready     = 1'b1;
        i_result       = 16'hDEAD;
        i_result_valid = 1'b1;
        @(negedge clk);
        i_op_ready     = 1'b0;
        i_result_valid = 1'b0;
        check({tag, " op_valid drop"}, 32'(o_op_valid), 32'd0);
        pulse_result(res, err);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5'h01,   16'h0001, 1'b0, 1'b1};
        vecs[1] = '{5'h02,   16'h0012, 1'b0, 1'b1};
        vecs[2] = '{K_ADD,   16'h0012, 1'b0, 1'b1};
        vecs[3] = '{K_SUB,   16'h0012, 1'b0, 1'b1};
        vecs[4] = '{K_ADD,   16'h0012, 1'b0, 1'b1};
        vecs[5] = '{5'b10110,16'h0012, 1'b0, 1'b1};
        vecs[6] = '{K_EQ,    16'h0012, 1'b0, 1'b1};
        vecs[7] = '{5'h03,   16'h0003, 1'b0, 1'b1};

        rst = 1'b1; i_key_data = '0; i_key_valid = 1'b0; i_op_ready = 1'b0;
        i_result = '0; i_result_valid = 1'b0; i_result_error = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset display", 32'(o_display), 32'd0);
        check("reset error", 32'(o_error), 32'd0);
        check("reset op_valid", 32'(o_op_valid), 32'd0);
        check("reset key_ready", 32'(o_key_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            press(vecs[i].key);
            check($sformatf("vec%0d display", i), 32'(o_display), 32'(vecs[i].disp));
            check($sformatf("vec%0d error", i), 32'(o_error), 32'(vecs[i].err));
            check($sformatf("vec%0d key_ready", i), 32'(o_key_ready), 32'(vecs[i].kr));
        end

        press(K_EQ);
        issue("add", 16'h0012, 16'h0003, 2'd0, 16'h0015, 1'b0);
        check("add result display", 32'(o_display), 32'h0015);
        press(5'h03);
        check("digit after result", 32'(o_display), 32'h0003);

        // Chained operation
        press(K_AC);
        check("ac display", 32'(o_display), 32'h0000);
        press(5'h05); press(K_MUL); press(5'h04);
        check("chain B display", 32'(o_display), 32'h0004);
        press(K_SUB);
        issue("mul", 16'h0005, 16'h0004, 2'd2, 16'h0014, 1'b0);
        check("chain A display", 32'(o_display), 32'h0014);
        press(5'h02);
        check("chain B2 display", 32'(o_display), 32'h0002);
        press(K_EQ);
        issue("sub", 16'h0014, 16'h0002, 2'd1, 16'h0012, 1'b0);
        check("sub result display", 32'(o_display), 32'h0012);

        // Operand overflow
        press(K_AC);
        press(5'h01); press(5'h02); press(5'h03); press(5'h04);
        check("four digits", 32'(o_display), 32'h1234);
        press(5'h05);
        check("fifth digit dropped", 32'(o_display), 32'h1234);
        check("fifth digit ready", 32'(o_key_ready), 32'd1);

        // Back-pressure from the arithmetic unit
        press(K_ADD); press(5'h01); press(K_EQ);
        i_key_data  = 5'h07;
        i_key_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d key_ready", c), 32'(o_key_ready), 32'd0);
            check($sformatf("hold%0d op_valid", c), 32'(o_op_valid), 32'd1);
            check($sformatf("hold%0d op_a", c), 32'(o_op_a), 32'h1234);
            check($sformatf("hold%0d op_b", c), 32'(o_op_b), 32'h0001);
            @(negedge clk);
        end
        i_key_valid = 1'b0;
        i_op_ready  = 1'b1;
        @(negedge clk);
        i_op_ready  = 1'b0;
        check("hold op_valid drop", 32'(o_op_valid), 32'd0);
        check("hold wait display", 32'(o_display), 32'h0001);
        pulse_result(16'h1235, 1'b0);
        check("hold result display", 32'(o_display), 32'h1235);

        // Divide by zero
        press(K_AC); press(5'h08); press(K_DIV); press(5'h00); press(K_EQ);
        issue("div", 16'h0008, 16'h0000, 2'd3, 16'h0000, 1'b1);
        check("err flag", 32'(o_error), 32'd1);
        check("err display", 32'(o_display), 32'd0);
        press(5'h07);
        check("err digit ignored flag", 32'(o_error), 32'd1);
        check("err digit ignored display", 32'(o_display), 32'd0);
        press(K_AC);
        check("ac clears error", 32'(o_error), 32'd0);
        check("ac display", 32'(o_display), 32'd0);
        press(5'h05);
        check("after ac digit", 32'(o_display), 32'h0005);
        pulse_result(16'hBEEF, 1'b0);
        check("stray result ignored", 32'(o_display), 32'h0005);

        // Reset while waiting for a result
        press(K_ADD); press(5'h01); press(K_EQ);
        check("pre-reset op_valid", 32'(o_op_valid), 32'd1);
        i_op_ready = 1'b1;
        @(negedge clk);
        i_op_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset op_valid", 32'(o_op_valid), 32'd0);
        check("midreset display", 32'(o_display), 32'd0);
        check("midreset key_ready", 32'(o_key_ready), 32'd1);
        pulse_result(16'h0077, 1'b0);
        check("late result ignored", 32'(o_display), 32'd0);
        press(5'h04);
        check("post-reset digit", 32'(o_display), 32'h0004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
